// File: rtl/hood_mode_ctrl.sv
// Range-hood operating-mode controller: fan levels, timed hurricane,
// delayed stop, self-clean and a run-time clean reminder.
//
// Ports:
//   clk, rst (async, active-low), tick (1 Hz strobe), power_on (level)
//   menu_btn, level_btn[LEVELS], hurricane_btn, clean_btn, hand_clean
//   state[3], fan_level[LW], menu_open, countdown[16], run_secs[24],
//   need_clean, hurricane_used
//
// Define HOOD_HURRICANE_LOCK_EN to allow hurricane once per power session.
module hood_mode_ctrl #(
  parameter int LEVELS      = 3,
  parameter int HURRICANE_S = 60,
  parameter int RETURN_S    = 60,
  parameter int CLEAN_S     = 180,
  parameter int REMIND_S    = 36000,
  parameter int LW          = $clog2(LEVELS+2)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick,
  input  logic              power_on,
  input  logic              menu_btn,
  input  logic [LEVELS-1:0] level_btn,
  input  logic              hurricane_btn,
  input  logic              clean_btn,
  input  logic              hand_clean,
  output logic [2:0]        state,
  output logic [LW-1:0]     fan_level,
  output logic              menu_open,
  output logic [15:0]       countdown,
  output logic [23:0]       run_secs,
  output logic              need_clean,
  output logic              hurricane_used
);

  typedef enum logic [2:0] {
    ST_STANDBY = 3'd0,
    ST_MENU    = 3'd1,
    ST_RUN     = 3'd2,
    ST_HURR    = 3'd3,
    ST_RETURN  = 3'd4,
    ST_CLEAN   = 3'd5,
    ST_OFF     = 3'd6
  } state_e;

`ifdef HOOD_HURRICANE_LOCK_EN
  localparam logic LOCK = 1'b1;
`else
  localparam logic LOCK = 1'b0;
`endif

  localparam logic [LW-1:0] LVL_TOP  = LW'(LEVELS);
  localparam logic [LW-1:0] LVL_HURR = LW'(LEVELS+1);

  state_e        state_q, state_d;
  logic [LW-1:0] lvl_q, lvl_d;
  logic [15:0]   cd_q, cd_d;
  logic [23:0]   secs_q, secs_d;
  logic          used_q, used_d;
  logic          arm_q;
  logic          clr_secs;
  logic          expire;
  logic [LW-1:0] sel;

  // Lowest set bit wins; 0 means no level requested.
  function automatic logic [LW-1:0] pick(input logic [LEVELS-1:0] b);
    pick = '0;
    for (int i = LEVELS-1; i >= 0; i--)
      if (b[i]) pick = LW'(i+1);
  endfunction

  assign sel    = pick(level_btn);
  assign expire = tick && (cd_q == 16'd1);

  always_comb begin
    state_d  = state_q;
    lvl_d    = lvl_q;
    cd_d     = cd_q;
    used_d   = used_q;
    clr_secs = 1'b0;
    if (!power_on) begin
      state_d = ST_OFF;
      lvl_d   = '0;
      cd_d    = '0;
      used_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_OFF: begin
          // arm_q holds off the first edge after reset release
          if (arm_q) state_d = ST_STANDBY;
        end
        ST_STANDBY: begin
          if (menu_btn) state_d = ST_MENU;
        end
        ST_MENU: begin
          if (menu_btn) begin
            state_d = ST_STANDBY;
          end else if (hurricane_btn) begin
            if (!used_q) begin
              state_d = ST_HURR;
              lvl_d   = LVL_HURR;
              cd_d    = 16'(HURRICANE_S);
              used_d  = LOCK;
            end
          end else if (clean_btn) begin
            state_d = ST_CLEAN;
            cd_d    = 16'(CLEAN_S);
          end else if (sel != '0) begin
            state_d = ST_RUN;
            lvl_d   = sel;
          end
        end
        ST_RUN: begin
          if (menu_btn) begin
            state_d = ST_RETURN;
            cd_d    = 16'(RETURN_S);
          end else if (sel != '0) begin
            lvl_d = sel;
          end
        end
        ST_HURR: begin
          if (menu_btn) begin
            state_d = ST_RETURN;
            lvl_d   = LVL_TOP;
            cd_d    = 16'(RETURN_S);
          end else if (expire) begin
            state_d = ST_RUN;
            lvl_d   = LVL_TOP;
            cd_d    = '0;
          end else if (tick && cd_q != '0) begin
            cd_d = cd_q - 16'd1;
          end
        end
        ST_RETURN: begin
          if (sel != '0) begin
            state_d = ST_RUN;
            lvl_d   = sel;
            cd_d    = '0;
          end else if (expire) begin
            state_d = ST_STANDBY;
            lvl_d   = '0;
            cd_d    = '0;
          end else if (tick && cd_q != '0) begin
            cd_d = cd_q - 16'd1;
          end
        end
        ST_CLEAN: begin
          if (expire) begin
            state_d  = ST_STANDBY;
            cd_d     = '0;
            clr_secs = 1'b1;
          end else if (tick && cd_q != '0) begin
            cd_d = cd_q - 16'd1;
          end
        end
        default: begin
          state_d = ST_OFF;
          lvl_d   = '0;
          cd_d    = '0;
        end
      endcase
    end
  end

  always_comb begin
    secs_d = secs_q;
    if (hand_clean || clr_secs)
      secs_d = '0;
    else if (tick && lvl_q != '0 && secs_q != '1)
      secs_d = secs_q + 24'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_OFF;
      lvl_q   <= '0;
      cd_q    <= '0;
      secs_q  <= '0;
      used_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      cd_q    <= cd_d;
      secs_q  <= secs_d;
      used_q  <= used_d;
      arm_q   <= 1'b1;
    end
  end

  assign state          = state_q;
  assign fan_level      = lvl_q;
  assign menu_open      = (state_q == ST_MENU);
  assign countdown      = cd_q;
  assign run_secs       = secs_q;
  assign need_clean     = (secs_q >= 24'(REMIND_S));
  assign hurricane_used = used_q;

endmodule

// File: tb/tb_hood_mode_ctrl.sv
// Table-driven bench for hood_mode_ctrl with a scoreboard queue.
// Vectors hold inputs and expected registered outputs after one edge.
module tb_hood_mode_ctrl;

  localparam int LEVELS = 3;
  localparam int LW     = $clog2(LEVELS+2);

`ifdef HOOD_HURRICANE_LOCK_EN
  localparam bit LOCK = 1'b1;
`else
  localparam bit LOCK = 1'b0;
`endif

  localparam logic [2:0] SB = 3'd0, MN = 3'd1, RN = 3'd2;
  localparam logic [2:0] HU = 3'd3, RE = 3'd4, CL = 3'd5;
  localparam logic [2:0] OF = 3'd6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              tick = 1'b0;
  logic              power_on = 1'b0;
  logic              menu_btn = 1'b0;
  logic [LEVELS-1:0] level_btn = '0;
  logic              hurricane_btn = 1'b0;
  logic              clean_btn = 1'b0;
  logic              hand_clean = 1'b0;
  logic [2:0]        state;
  logic [LW-1:0]     fan_level;
  logic              menu_open;
  logic [15:0]       countdown;
  logic [23:0]       run_secs;
  logic              need_clean;
  logic              hurricane_used;

  hood_mode_ctrl #(
    .LEVELS(LEVELS), .HURRICANE_S(5), .RETURN_S(3),
    .CLEAN_S(4), .REMIND_S(10)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .power_on(power_on),
    .menu_btn(menu_btn), .level_btn(level_btn),
    .hurricane_btn(hurricane_btn), .clean_btn(clean_btn),
    .hand_clean(hand_clean), .state(state), .fan_level(fan_level),
    .menu_open(menu_open), .countdown(countdown),
    .run_secs(run_secs), .need_clean(need_clean),
    .hurricane_used(hurricane_used)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pwr, tk, mn;
    logic [2:0]  lv;
    logic        hr, cl, hc;
    logic [2:0]  st;
    logic [2:0]  fan;
    logic [15:0] cd;
    logic [23:0] secs;
    logic        nc, hu;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   vec_n  = 0;

  function automatic vec_t mk(
    input logic pwr, tk, mn, input logic [2:0] lv,
    input logic hr, cl, hc, input logic [2:0] st, fan,
    input int cd, secs, input logic nc, hu);
    vec_t v;
    v.pwr = pwr; v.tk = tk; v.mn = mn; v.lv = lv;
    v.hr = hr; v.cl = cl; v.hc = hc; v.st = st; v.fan = fan;
    v.cd = 16'(cd); v.secs = 24'(secs); v.nc = nc; v.hu = hu;
    return v;
  endfunction

  task automatic chk(input string nm, input longint act,
                     input longint want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s vec %0d: got %0d want %0d",
               nm, vec_n, act, want);
    end
  endtask

  task automatic compare();
    vec_t e;
    e = exp_q.pop_front();
    chk("state", state, e.st);
    chk("fan_level", fan_level, e.fan);
    chk("countdown", countdown, e.cd);
    chk("run_secs", run_secs, e.secs);
    chk("need_clean", need_clean, e.nc);
    chk("menu_open", menu_open, e.st == MN);
    chk("hurricane_used", hurricane_used, LOCK ? e.hu : 1'b0);
    vec_n++;
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    power_on      = v.pwr;
    tick          = v.tk;
    menu_btn      = v.mn;
    level_btn     = v.lv;
    hurricane_btn = v.hr;
    clean_btn     = v.cl;
    hand_clean    = v.hc;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    // boot, level select, run counting, reminder, manual clear
    tbl.push_back(mk(1,0,0,0,0,0,0, OF,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, SB,0,0,0,0,0));
    tbl.push_back(mk(1,0,1,0,0,0,0, MN,0,0,0,0,0));
    tbl.push_back(mk(1,0,0,3'b110,0,0,0, RN,2,0,0,0,0));
    for (int k = 1; k <= 10; k++)
      tbl.push_back(mk(1,1,0,0,0,0,0, RN,2,0,k,k>=10,0));
    tbl.push_back(mk(1,0,0,0,0,0,1, RN,2,0,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,1, RN,2,0,0,0,0));
    // delayed stop, aborted then run to expiry
    tbl.push_back(mk(1,0,1,0,0,0,0, RE,2,3,0,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0, RE,2,2,1,0,0));
    tbl.push_back(mk(1,0,0,3'b100,0,0,0, RN,3,0,1,0,0));
    tbl.push_back(mk(1,0,1,0,0,0,0, RE,3,3,1,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0, RE,3,2,2,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0, RE,3,1,3,0,0));
    tbl.push_back(mk(1,1,0,0,0,0,0, SB,0,0,4,0,0));
    // hurricane to expiry, level buttons ignored
    tbl.push_back(mk(1,0,1,0,0,0,0, MN,0,0,4,0,0));
    tbl.push_back(mk(1,0,0,0,1,0,0, HU,4,5,4,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, HU,4,4,5,0,1));
    tbl.push_back(mk(1,1,0,3'b001,0,0,0, HU,4,3,6,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, HU,4,2,7,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, HU,4,1,8,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, RN,3,0,9,0,1));
    // return from RUN level 1
    tbl.push_back(mk(1,0,1,0,0,0,0, RE,3,3,9,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, RE,3,2,10,1,1));
    tbl.push_back(mk(1,0,0,3'b001,0,0,0, RN,1,0,10,1,1));
    tbl.push_back(mk(1,0,1,0,0,0,1, RE,1,3,0,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, RE,1,2,1,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, RE,1,1,2,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, SB,0,0,3,0,1));
    // self-clean to expiry with run_secs=6
    tbl.push_back(mk(1,0,1,0,0,0,0, MN,0,0,3,0,1));
    tbl.push_back(mk(1,0,0,3'b001,0,0,0, RN,1,0,3,0,1));
    tbl.push_back(mk(1,0,1,0,0,0,0, RE,1,3,3,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, RE,1,2,4,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, RE,1,1,5,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, SB,0,0,6,0,1));
    tbl.push_back(mk(1,0,1,0,0,0,0, MN,0,0,6,0,1));
    tbl.push_back(mk(1,0,0,0,0,1,0, CL,0,4,6,0,1));
    tbl.push_back(mk(1,1,1,3'b111,0,0,0, CL,0,3,6,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, CL,0,2,6,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, CL,0,1,6,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, SB,0,0,0,0,1));
    // second clean aborted by power-off
    tbl.push_back(mk(1,0,1,0,0,0,0, MN,0,0,0,0,1));
    tbl.push_back(mk(1,0,0,3'b010,0,0,0, RN,2,0,0,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, RN,2,0,1,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, RN,2,0,2,0,1));
    tbl.push_back(mk(1,0,1,0,0,0,0, RE,2,3,2,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, RE,2,2,3,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, RE,2,1,4,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, SB,0,0,5,0,1));
    tbl.push_back(mk(1,0,1,0,0,0,0, MN,0,0,5,0,1));
    tbl.push_back(mk(1,0,0,0,0,1,0, CL,0,4,5,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, CL,0,3,5,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, CL,0,2,5,0,1));
    tbl.push_back(mk(0,0,0,0,0,0,0, OF,0,0,5,0,0));
    tbl.push_back(mk(1,0,0,0,0,0,0, SB,0,0,5,0,0));
    // menu beats hurricane; tick on entry edge not counted
    tbl.push_back(mk(1,0,1,0,0,0,0, MN,0,0,5,0,0));
    tbl.push_back(mk(1,0,1,0,1,0,0, SB,0,0,5,0,0));
    tbl.push_back(mk(1,0,1,0,0,0,0, MN,0,0,5,0,0));
    tbl.push_back(mk(1,1,0,0,1,0,0, HU,4,5,5,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, HU,4,4,6,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, HU,4,3,7,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, HU,4,2,8,0,1));
    tbl.push_back(mk(1,1,0,0,0,0,0, HU,4,1,9,0,1));
    // power-off beats expiry and buttons
    tbl.push_back(mk(0,1,1,0,0,0,1, OF,0,0,0,0,0));

    // reset state while rst is held low
    power_on = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_q.push_back(mk(1,0,0,0,0,0,0, OF,0,0,0,0,0));
    compare();
    rst = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // hurricane lock across one power session
    apply(mk(1,0,0,0,0,0,0, SB,0,0,0,0,0));
    apply(mk(1,0,1,0,0,0,0, MN,0,0,0,0,0));
    apply(mk(1,0,0,0,1,0,0, HU,4,5,0,0,1));
    apply(mk(1,0,1,0,0,0,0, RE,3,3,0,0,1));
    apply(mk(1,1,0,0,0,0,0, RE,3,2,1,0,1));
    apply(mk(1,1,0,0,0,0,0, RE,3,1,2,0,1));
    apply(mk(1,1,0,0,0,0,0, SB,0,0,3,0,1));
    apply(mk(1,0,1,0,0,0,0, MN,0,0,3,0,1));
    if (LOCK)
      apply(mk(1,0,0,0,1,0,0, MN,0,0,3,0,1));
    else
      apply(mk(1,0,0,0,1,0,0, HU,4,5,3,0,0));

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hood_mode_ctrl.md
# hood_mode_ctrl

Parametrised range-hood operating-mode controller. It replaces the fixed three-speed mode/return/self-clean handling with:
- a configurable number of fan levels;
- a timed hurricane level;
- a timed delayed-stop (return) phase;
- a timed self-clean;
- a cumulative run-time counter with a clean reminder.

It sits between the debounced button decode and the fan/LED/display logic, and is gated by the power state from the on/off block.

## Interface

Parameters:
- LEVELS, 3: number of normal fan levels (1..LEVELS); hurricane is level LEVELS+1. Must be ≥1.
- HURRICANE_S, 60: hurricane duration in seconds.
- RETURN_S, 60: delayed-stop duration in seconds.
- CLEAN_S, 180: self-clean duration in seconds.
- REMIND_S, 36000: cumulative fan-on seconds at which need_clean asserts.
- LW, $clog2(LEVELS+2): fan_level width.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- tick  in  1  one-cycle 1 Hz strobe.
- power_on  in  1  level; machine is on.
- menu_btn  in  1  one-cycle pulse.
- level_btn  in  LEVELS  pulse vector; bit i selects level i+1.
- hurricane_btn  in  1  pulse.
- clean_btn  in  1  pulse.
- hand_clean  in  1  pulse; manual cleaning done.
- state  out  3  OFF=6, STANDBY=0, MENU=1, RUN=2, HURRICANE=3, RETURN=4, CLEAN=5.
- fan_level  out  LW  0=off, 1..LEVELS, LEVELS+1=hurricane.
- menu_open  out  1  state==MENU.
- countdown  out  16  seconds remaining in HURRICANE/RETURN/CLEAN; 0 in all other states.
- run_secs  out  24  cumulative fan-on seconds.
- need_clean  out  1  run_secs ≥ REMIND_S.
- hurricane_used  out  1  hurricane consumed this power session.

## Operation

- **Power off.** power_on low forces OFF from any state:
  - fan_level=0, countdown=0, hurricane_used cleared;
  - run_secs and need_clean are retained.
  - OFF→STANDBY when power_on is high.
- **STANDBY.** menu_btn→MENU. All other buttons are ignored.
- **MENU.** fan_level=0. Input priority, highest first:
  1. menu_btn→STANDBY.
  2. hurricane_btn→HURRICANE: countdown=HURRICANE_S, hurricane_used set. Ignored if hurricane_used=1; state stays MENU.
  3. clean_btn→CLEAN: countdown=CLEAN_S.
  4. Lowest set level_btn bit i→RUN at level i+1.
- **RUN.**
  - level_btn changes level directly; lowest set bit wins.
  - menu_btn→RETURN with countdown=RETURN_S; fan_level is held.
- **HURRICANE.**
  - level_btn is ignored.
  - menu_btn→RETURN with countdown=RETURN_S; fan_level becomes LEVELS.
  - On expiry→RUN at level LEVELS.
- **RETURN.**
  - level_btn aborts to RUN at the selected level.
  - On expiry→STANDBY.
- **CLEAN.**
  - fan_level=0; all buttons are ignored.
  - On expiry→STANDBY, and run_secs is cleared.
  - Power-off during CLEAN aborts it without clearing run_secs.
- **Countdown.**
  - Loaded on state entry; decrements on tick.
  - The tick that takes it from 1 to 0 causes the exit transition in that same edge.
  - A tick coincident with the entry edge is not counted.
- **run_secs.**
  - +1 per tick while fan_level≠0; saturates at 2^24−1.
  - hand_clean clears it in any state. If it coincides with a tick, the clear wins.
- **need_clean.** Recomputed from the registered run_secs.

## Timing

- All outputs are registered and change one clk edge after the sampled input/tick.
- Reset values:
  - state=OFF, fan_level=0, menu_open=0, countdown=0;
  - run_secs=0, need_clean=0, hurricane_used=0.
- First possible STANDBY is the second edge after rst deasserts with power_on high.
- Button pulses arriving in a state that ignores them have no delayed effect.
- power_on low has priority over every button and over expiry in the same cycle.

## Configuration

- **HOOD_HURRICANE_LOCK_EN defined:** hurricane may be entered once per power session, as described above.
- **Undefined:** hurricane_btn in MENU always enters HURRICANE, and hurricane_used is tied 0.

## Test plan

Bench parameters: LEVELS=3, HURRICANE_S=5, RETURN_S=3, CLEAN_S=4, REMIND_S=10.

- rst low, then power_on high → state 6 with all outputs 0; STANDBY two edges after release. menu_btn → menu_open=1.
- MENU, level_btn=3'b110 → RUN, fan_level=2. 7 ticks → run_secs=7. 3 more ticks → need_clean=1. hand_clean → run_secs=0, need_clean=0.
- MENU, hurricane_btn → fan_level=4, countdown=5. After 5 ticks → RUN, fan_level=3. Re-enter MENU, press hurricane_btn → stays MENU (with lock), hurricane_used=1.
- RUN level 1, menu_btn → RETURN, countdown=3. Tick at countdown=2, then level_btn=3'b100 → RUN, fan_level=3. Repeat without intervention → STANDBY after 3 ticks.
- run_secs=6, MENU, clean_btn → CLEAN, fan_level=0. 4 ticks → STANDBY, run_secs=0. Second run: power_on low at countdown=2 → OFF, run_secs retained.
- hurricane_btn and menu_btn pulsed together in MENU → STANDBY, hurricane_used stays 0. Tick on the entry edge → countdown still equals the full load value.
